// File: rtl/tag_read_responder.sv
// Tag-read responder: direct-indexed tag/data store with a fill port, answering
// set-index read requests on an R channel through a two-entry output buffer.
module tag_read_responder #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 72,
  parameter int TAG_W  = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic              fill_en_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              flush_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [1:0]        credits_q, credits_d;
  logic              arready_q;

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0]  head_tag_q, head_tag_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] lookup_data;
  logic [TAG_W-1:0]  lookup_tag;

  assign accept = arvalid_i & arready_q;
  assign pop    = head_valid_q & rready_i;

  // A same-cycle fill to the requested index bypasses the store; a same-cycle
  // flush makes any stored entry look invalid.
  always_comb begin
    lookup_data = '0;
    lookup_tag  = '1;
    if (fill_en_i && (fill_idx_i == araddr_i)) begin
      lookup_data = fill_data_i;
      lookup_tag  = fill_tag_i;
    end else if (valid_q[araddr_i] && !flush_i) begin
      lookup_data = data_mem[araddr_i];
      lookup_tag  = tag_mem[araddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      data_mem[fill_idx_i] <= fill_data_i;
      tag_mem[fill_idx_i]  <= fill_tag_i;
    end
  end

  // Fill is applied after flush so a filled entry survives a simultaneous flush.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end
    if (fill_en_i) begin
      valid_d[fill_idx_i] = 1'b1;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q + 2'd1;
    end else if (!accept && pop) begin
      credits_d = credits_q - 2'd1;
    end
  end

  // The head register drives the R channel directly; the skid entry only
  // fills when a response arrives while the head is stalled.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_tag_d   = head_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (!head_valid_q || pop) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_tag_d   = skid_tag_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = lookup_data;
          skid_tag_d  = lookup_tag;
        end
      end else if (accept) begin
        head_valid_d = 1'b1;
        head_data_d  = lookup_data;
        head_tag_d   = lookup_tag;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = lookup_data;
      skid_tag_d   = lookup_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      credits_q    <= 2'd0;
      arready_q    <= 1'b0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      credits_q    <= credits_d;
      arready_q    <= (credits_d != 2'd2);
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_tag_q   <= head_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = head_valid_q;
  assign rdata_o   = head_data_q;
  assign rtag_o    = head_tag_q;

endmodule

// File: doc/tag_read_responder.md
Name: tag_read_responder

Overview:
- Responder end of the tag-read R channel. Accepts tag-read requests by set index and returns the stored 72-bit data word plus 56-bit tag on an AXI-style R channel (rdata/rtag/rvalid/rready).
- The tag comparator consumes these responses.
- Holds a small direct-indexed tag/data store, updated by a fill port from the miss path.
- Includes a 2-entry output buffer so R-channel backpressure never drops or reorders responses.

Parameters:
- IDX_W, 6, set-index width; store depth = 2**IDX_W entries.
- DATA_W, 72, data word width.
- TAG_W, 56, tag width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- araddr_i  input  IDX_W  set index of the read request.
- arvalid_i  input  1  read request valid.
- arready_o  output  1  read request accepted when arvalid_i && arready_o at a rising edge.
- rdata_o  output  DATA_W  response data.
- rtag_o  output  TAG_W  response tag.
- rvalid_o  output  1  response valid.
- rready_i  input  1  response consumed when rvalid_o && rready_i.
- fill_en_i  input  1  write the tag/data store this cycle.
- fill_idx_i  input  IDX_W  fill set index.
- fill_tag_i  input  TAG_W  fill tag.
- fill_data_i  input  DATA_W  fill data.
- flush_i  input  1  invalidate all entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits cleared; output buffer emptied; credit counter = 0.
  - rvalid_o=0, rdata_o=0, rtag_o=0, arready_o=0.
  - Storage data/tag arrays are not reset.
- Reset mid-operation:
  - in-flight and buffered responses are discarded, never emitted.
  - First cycle after release: arready_o=1.
- Credit counter (0..2) = in-flight reads + buffered responses.
  - +1 on request accept, -1 on response pop; both in the same cycle leaves it unchanged.
  - arready_o = (credits < 2), registered. No combinational path from rready_i or arvalid_i to arready_o.
- Latency:
  - Request accepted at edge t → response is at the buffer head and rvalid_o=1 from edge t+1, if the buffer was empty.
  - Sustained throughput is 1 response/cycle with rready_i held high.
- Lookup:
  - Valid entry: rtag_o = stored tag, rdata_o = stored data.
  - Invalid entry: rtag_o = all ones (sentinel), rdata_o = 0.
- Fill:
  - On fill_en_i: tag/data written at fill_idx_i; valid bit set at the edge.
  - Fill and read to the same index in the same cycle: the read returns the NEW fill values (write-first bypass).
- Flush:
  - flush_i clears all valid bits at the edge.
  - A read accepted in the same cycle as flush_i returns the sentinel.
  - flush_i and fill_en_i together: the filled entry ends valid (fill wins).
  - Responses already in flight/buffered are unaffected.
- Output hold:
  - While rvalid_o && !rready_i, rdata_o/rtag_o/rvalid_o stay stable.
  - Responses are returned in strict request order.
- Empty buffer: rvalid_o=0; rdata_o/rtag_o keep their last value. Reset value is 0.
- Full (credits=2): arvalid_i is ignored (no accept) until a pop occurs. arready_o reasserts the cycle after the pop.

Test Plan:
- Reset → rvalid_o=0, rdata_o=0, rtag_o=0, arready_o=0 during reset, 1 the cycle after release. Then read idx 7 → rtag_o=all ones, rdata_o=0.
- Fill idx 5 (tag 10, data 100), then read idx 5 at edge t → rvalid_o=1 at t+1 with rtag_o=10, rdata_o=100. Fill idx 6 (tag 11, data 200) and read 6 → tag 11, data 200.
- rready_i=0 with arvalid_i held and reads to idx 5, 6, 7 →
  - two accepted, then arready_o=0;
  - outputs stable at tag 10/data 100;
  - release rready_i → responses 10/100, 11/200, sentinel in order;
  - third read accepted the cycle after the first pop.
- Same-cycle fill idx 3 (tag 42, data 300) and read idx 3 → response tag 42, data 300.
- rready_i=1, back-to-back reads of idx 5, 6, 5, 6 for 4 cycles → 4 consecutive rvalid_o cycles, no bubbles, correct values.
- Flush after filling idx 5, then read idx 5 → sentinel. Assert rst_n low with 2 responses buffered → no response emitted after release.
